// File: rtl/hazard_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states, Jump
// encodings, the shadow-stage record and a destination-match helper.
package hazard_pkg;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [1:0] J_NONE = 2'b00;
  localparam logic [1:0] J_J    = 2'b01;
  localparam logic [1:0] J_JAL  = 2'b10;
  localparam logic [1:0] J_JR   = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic       load;
    logic       store;
    logic       wr;
    logic [4:0] dst;
  } stage_t;

  // Register 0 is hard-wired, so writes to it never produce a dependency.
  function automatic logic writes_reg(stage_t s, logic [4:0] r);
    return s.valid & s.wr & (s.dst != REG_ZERO) & (s.dst == r);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational compare of the ID sources against the EX/MEM shadow slots.
// HAZARD_FORWARD_EN defined: only load-use and jr dependencies stall.
module hazard_detect
  import hazard_pkg::*;
(
  input  stage_t     ex,
  input  stage_t     mem,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [1:0] id_jump,
  output logic       stall
);

`ifdef HAZARD_FORWARD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  stage_t     slot [2];
  logic [1:0] hit_rs;
  logic [1:0] hit_rt;
  logic       load_use;
  logic       jr_hz;
  logic       dep_hz;

  assign slot[0] = ex;
  assign slot[1] = mem;

  // Slot 0 is EX, slot 1 is MEM.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign hit_rs[gi] = writes_reg(slot[gi], id_rs);
    assign hit_rt[gi] = id_uses_rt & writes_reg(slot[gi], id_rt);
  end

  assign load_use = ex.load & (hit_rs[0] | hit_rt[0]);
  assign jr_hz    = (id_jump == J_JR) & (|hit_rs);
  // Without a forwarding unit every in-flight producer must retire first.
  assign dep_hz   = ~FWD_EN & (|(hit_rs | hit_rt));
  assign stall    = load_use | jr_hz | dep_hz;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use/jr stalls, jump flushes and the
// data-memory freeze handshake. Optional build macro: HAZARD_FORWARD_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] id_dst,
  input  logic       id_regwrite,
  input  logic [1:0] id_memread,
  input  logic [1:0] id_memwrite,
  input  logic [1:0] id_jump,
  input  logic       mem_ack,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       idex_we,
  output logic       exmem_we,
  output logic       memwb_we,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       mem_req,
  output logic       hz_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;
  stage_t        ex_reg, ex_next;
  stage_t        mem_reg, mem_next;
  stage_t        id_stage;
  logic          stall;
  logic          advance;
  logic          req;

  assign id_stage = '{valid: id_valid, load: |id_memread, store: |id_memwrite,
                      wr: id_regwrite, dst: id_dst};

  hazard_detect u_detect (
    .ex         (ex_reg),
    .mem        (mem_reg),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .id_jump    (id_jump),
    .stall      (stall)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    err_next    = err_reg;
    req         = 1'b0;
    advance     = 1'b1;

    case (state_reg)
      RUN: begin
        req = mem_reg.valid & (mem_reg.load | mem_reg.store);
        if (req && !mem_ack) begin
          advance    = 1'b0;
          state_next = MEM_WAIT;
          cnt_next   = '0;
        end
      end
      MEM_WAIT: begin
        req = 1'b1;
        if (mem_ack) begin
          state_next = RUN;
        end else if (cnt_reg + 1'b1 == CW'(MEM_TIMEOUT)) begin
          // Counting the initial RUN cycle, MEM_TIMEOUT cycles were frozen.
          err_next   = 1'b1;
          state_next = RUN;
        end else begin
          advance  = 1'b0;
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = RUN;
    endcase

    pc_we       = advance & ~stall;
    ifid_we     = advance & ~stall;
    idex_we     = advance;
    exmem_we    = advance;
    memwb_we    = advance;
    idex_bubble = advance & stall;
    ifid_flush  = advance & ~stall & id_valid & (id_jump != J_NONE);
    mem_req     = req;

    if (reset) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      mem_req     = 1'b0;
    end

    mem_next = advance ? ex_reg : mem_reg;
    ex_next  = !advance ? ex_reg : (stall ? '0 : id_stage);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      ex_reg    <= '0;
      mem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      ex_reg    <= ex_next;
      mem_reg   <= mem_next;
    end
  end

  assign hz_err = err_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic, expectations from a behavioural pipeline model.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rt, id_regwrite, mem_ack;
  logic [4:0] id_rs, id_rt, id_dst;
  logic [1:0] id_memread, id_memwrite, id_jump;
  logic       pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic       ifid_flush, idex_bubble, mem_req, hz_err;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_jump(id_jump),
    .mem_ack(mem_ack), .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .memwb_we(memwb_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .mem_req(mem_req), .hz_err(hz_err)
  );

  typedef struct {
    bit v;
    bit ld;
    bit st;
    bit wr;
    int dst;
  } slot_t;

  typedef struct {
    logic [8:0] outs;  // pc,ifid,idex,exmem,memwb,flush,bubble,req,err
    string      tag;
  } exp_t;

  exp_t  sb[$];
  slot_t m_ex, m_mem;
  bit    m_wait, m_err;
  int    m_frozen;
  int    checks = 0;
  int    passed = 0;
  string phase = "reset";

  function automatic bit produces(slot_t s, int r);
    return s.v && s.wr && s.dst != 0 && s.dst == r;
  endfunction

  function automatic slot_t empty_slot();
    slot_t s;
    s.v = 0; s.ld = 0; s.st = 0; s.wr = 0; s.dst = 0;
    return s;
  endfunction

  task automatic cycle(input bit rst, input bit v, input int rs, input int rt,
                       input bit urt, input int dst, input bit rw, input int mr,
                       input int mw, input int jmp, input bit ack);
    exp_t  x;
    bit    req, tmo, freeze, stall, dep, flush;
    slot_t nxt;
    @(negedge clk);
    reset = rst; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = urt;
    id_dst = 5'(dst); id_regwrite = rw; id_memread = 2'(mr); id_memwrite = 2'(mw);
    id_jump = 2'(jmp); mem_ack = ack;
    #1;
    if (rst) begin
      x.outs = {5'b00000, 1'b1, 1'b1, 1'b0, m_err};
      m_ex = empty_slot(); m_mem = empty_slot();
      m_wait = 0; m_err = 0; m_frozen = 0;
    end else begin
      req    = m_wait || (m_mem.v && (m_mem.ld || m_mem.st));
      tmo    = m_wait && !ack && m_frozen == TIMEOUT;
      freeze = req && !ack && !tmo;
      dep    = produces(m_ex, rs) || (urt && produces(m_ex, rt));
      stall  = m_ex.ld && dep;
      if (jmp == 3 && (produces(m_ex, rs) || produces(m_mem, rs))) stall = 1;
`ifndef HAZARD_FORWARD_EN
      if (dep || produces(m_mem, rs) || (urt && produces(m_mem, rt))) stall = 1;
`endif
      if (freeze) begin
        x.outs = {5'b00000, 1'b0, 1'b0, 1'b1, m_err};
        m_wait = 1;
        m_frozen++;
      end else begin
        flush  = v && jmp != 0 && !stall;
        x.outs = {!stall, !stall, 3'b111, flush, stall, req, m_err};
        nxt    = empty_slot();
        if (!stall) begin
          nxt.v = v; nxt.ld = (mr != 0); nxt.st = (mw != 0); nxt.wr = rw; nxt.dst = dst;
        end
        m_mem = m_ex;
        m_ex  = nxt;
        if (tmo) m_err = 1;
        m_wait = 0;
        m_frozen = 0;
      end
    end
    x.tag = phase;
    sb.push_back(x);
  endtask

  task automatic ins(input bit v, input int rs, input int rt, input bit urt,
                     input int dst, input bit rw, input int mr, input int mw,
                     input int jmp, input bit ack);
    cycle(1'b0, v, rs, rt, urt, dst, rw, mr, mw, jmp, ack);
  endtask

  task automatic nops(input int n, input bit ack);
    for (int i = 0; i < n; i++) ins(0, 0, 0, 0, 0, 0, 0, 0, 0, ack);
  endtask

  // Monitor: one comparison per presented cycle, decoupled from the driver.
  initial begin
    exp_t       x;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        x   = sb.pop_front();
        act = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_bubble, mem_req, hz_err};
        checks++;
        if (act === x.outs) passed++;
        else $display("FAIL %s: outputs got %b expected %b (pc,ifid,idex,exmem,memwb,flush,bubble,req,err)",
                      x.tag, act, x.outs);
      end
    end
  end

  initial begin
    reset = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_dst = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_jump = 0; mem_ack = 0;
    m_ex = empty_slot(); m_mem = empty_slot();

    phase = "reset";
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    phase = "first_cycle";
    nops(1, 0);

    phase = "load_use";
    ins(1, 1, 0, 0, 8, 1, 1, 0, 0, 1);
    ins(1, 8, 2, 1, 9, 1, 0, 0, 0, 1);
    ins(1, 8, 2, 1, 9, 1, 0, 0, 0, 1);
    ins(1, 8, 2, 1, 9, 1, 0, 0, 0, 1);
    nops(3, 1);

    phase = "dst_zero";
    ins(1, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    ins(1, 0, 0, 1, 9, 1, 0, 0, 0, 1);
    nops(3, 1);

    phase = "jump";
    ins(1, 1, 2, 0, 0, 0, 0, 0, 1, 1);
    nops(2, 1);
    phase = "jr_stall";
    ins(1, 1, 0, 0, 9, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) ins(1, 9, 0, 0, 0, 0, 0, 0, 3, 1);
    nops(3, 1);

    phase = "sw_wait";
    ins(1, 1, 2, 1, 0, 0, 0, 1, 0, 0);
    nops(4, 0);
    nops(1, 1);
    nops(3, 1);

    phase = "timeout";
    ins(1, 1, 2, 1, 0, 0, 0, 1, 0, 0);
    nops(24, 0);
    phase = "timeout_reset";
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nops(2, 0);

    phase = "dependency";
    ins(1, 1, 2, 0, 5, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) ins(1, 5, 0, 0, 6, 1, 0, 0, 0, 1);
    nops(3, 1);

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      bit rst, v, urt, rw, ack;
      int rs, rt, dst, mr, mw, jmp;
      rst = ($urandom_range(0, 79) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rs  = $urandom_range(0, 3);
      rt  = $urandom_range(0, 3);
      dst = $urandom_range(0, 3);
      urt = $urandom_range(0, 1);
      rw  = $urandom_range(0, 1);
      mr  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      mw  = (mr == 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      jmp = ($urandom_range(0, 7) < 5) ? 0 : $urandom_range(1, 3);
      ack = ($urandom_range(0, 2) != 0);
      cycle(rst, v, rs, rt, urt, dst, rw, mr, mw, jmp, ack);
    end

    @(negedge clk);
    #5;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: pending got %0d expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
